// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through byte FIFO.
// CTS (active-low ready) is raised once the FIFO is within CTS_MARGIN entries of full.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          Baud16Tick,
  input  logic                          RxD_ser,
  output logic                          CTS,
  output logic [7:0]                    TxD_par,
  output logic                          TxD_valid,
  input  logic                          TxD_pop,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] CTS_LEVEL  = LW'(FIFO_DEPTH - CTS_MARGIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rxState_t;

  logic          rxMeta_r, rxSync_r, rxPrev_r;
  logic [1:0]    armed_r;
  logic          fallEdge_s;
  rxState_t      state_r, state_s;
  logic [3:0]    tickCnt_r, tickCnt_s;
  logic [2:0]    bitIdx_r, bitIdx_s;
  logic [7:0]    shift_r, shift_s;
  logic          stopOk_s, stopBad_s;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_r, rdPtr_r, wrPtrNext_s, rdPtrNext_s;
  logic [LW-1:0] levelNext_s;
  logic          full_s, popOk_s, push_s, drop_s;
  logic [7:0]    headNext_s;

  // Line synchronizer; rxPrev_r stays 0 until the chain holds real line samples,
  // so the reset value of the flops can never fake a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxMeta_r <= 1'b1;
      rxSync_r <= 1'b1;
      armed_r  <= 2'b00;
      rxPrev_r <= 1'b0;
    end else begin
      rxMeta_r <= RxD_ser;
      rxSync_r <= rxMeta_r;
      armed_r  <= {armed_r[0], 1'b1};
      rxPrev_r <= rxSync_r & armed_r[1];
    end
  end

  assign fallEdge_s = rxPrev_r & ~rxSync_r;

  // Receive FSM state, counters and shift register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= IDLE;
      tickCnt_r <= 4'd0;
      bitIdx_r  <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_s;
      tickCnt_r <= tickCnt_s;
      bitIdx_r  <= bitIdx_s;
      shift_r   <= shift_s;
    end
  end

  // Receive FSM next state; all timing advances only on Baud16Tick.
  always_comb begin
    state_s   = state_r;
    tickCnt_s = tickCnt_r;
    bitIdx_s  = bitIdx_r;
    shift_s   = shift_r;
    stopOk_s  = 1'b0;
    stopBad_s = 1'b0;
    case (state_r)
      IDLE: begin
        tickCnt_s = 4'd0;
        bitIdx_s  = 3'd0;
        if (fallEdge_s) state_s = START;
        else            state_s = IDLE;
      end
      START: begin
        if (Baud16Tick) begin
          if (tickCnt_r == 4'd7) begin
            tickCnt_s = 4'd0;
            bitIdx_s  = 3'd0;
            if (rxSync_r) state_s = IDLE;
            else          state_s = DATA;
          end else begin
            tickCnt_s = tickCnt_r + 4'd1;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (Baud16Tick) begin
          tickCnt_s = tickCnt_r + 4'd1;
          if (tickCnt_r == 4'd15) begin
            shift_s = {rxSync_r, shift_r[7:1]};
            if (bitIdx_r == 3'd7) state_s = STOP;
            else                  bitIdx_s = bitIdx_r + 3'd1;
          end else begin
            shift_s = shift_r;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (Baud16Tick) begin
          tickCnt_s = tickCnt_r + 4'd1;
          if (tickCnt_r == 4'd15) begin
            state_s = IDLE;
            if (rxSync_r) stopOk_s  = 1'b1;
            else          stopBad_s = 1'b1;
          end else begin
            state_s = STOP;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign full_s      = (fifo_level == FULL_LEVEL);
  assign popOk_s     = TxD_pop & TxD_valid;
  assign push_s      = stopOk_s & (~full_s | popOk_s);
  assign drop_s      = stopOk_s & full_s & ~popOk_s;
  assign wrPtrNext_s = push_s  ? wrPtr_r + PW'(1) : wrPtr_r;
  assign rdPtrNext_s = popOk_s ? rdPtr_r + PW'(1) : rdPtr_r;

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    levelNext_s = fifo_level;
    case ({push_s, popOk_s})
      2'b10:   levelNext_s = fifo_level + LW'(1);
      2'b01:   levelNext_s = fifo_level - LW'(1);
      default: levelNext_s = fifo_level;
    endcase
  end

  // Head lookahead so TxD_par can be registered: a byte pushed into a slot that
  // becomes the head this cycle bypasses the storage array.
  always_comb begin
    headNext_s = mem_r[rdPtrNext_s];
    if (push_s && (wrPtr_r == rdPtrNext_s)) headNext_s = shift_r;
    else                                     headNext_s = mem_r[rdPtrNext_s];
  end

  // Storage array holds data only; validity is tracked by the pointers.
  always_ff @(posedge sys_clk) begin
    if (push_s) mem_r[wrPtr_r] <= shift_r;
  end

  // Pointers and all registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      fifo_level <= '0;
      TxD_valid  <= 1'b0;
      TxD_par    <= 8'h00;
      CTS        <= 1'b1;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wrPtr_r    <= wrPtrNext_s;
      rdPtr_r    <= rdPtrNext_s;
      fifo_level <= levelNext_s;
      TxD_valid  <= (levelNext_s != '0);
      TxD_par    <= headNext_s;
      CTS        <= (levelNext_s >= CTS_LEVEL);
      frame_err  <= stopBad_s;
      overrun    <= drop_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written
// sequences for glitch, CTS/overrun, full-FIFO streaming and mid-frame reset.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       Baud16Tick = 1'b0;
  logic       RxD_ser = 1'b1;
  logic       TxD_pop = 1'b0;
  logic       CTS, TxD_valid, frame_err, overrun;
  logic [7:0] TxD_par;
  logic [4:0] fifo_level;

  int compared   = 0;
  int mismatched = 0;
  int feSeen     = 0;
  int ovSeen     = 0;
  int tickDiv    = 0;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .CTS_MARGIN(MARGIN)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .Baud16Tick (Baud16Tick),
    .RxD_ser    (RxD_ser),
    .CTS        (CTS),
    .TxD_par    (TxD_par),
    .TxD_valid  (TxD_valid),
    .TxD_pop    (TxD_pop),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  // Baud16Tick: one cycle in three, changed on the falling edge.
  always @(negedge sys_clk) begin
    tickDiv = (tickDiv == 2) ? 0 : tickDiv + 1;
    Baud16Tick = (tickDiv == 0);
  end

  // Count high cycles of the error pulses.
  always @(negedge sys_clk) begin
    if (frame_err === 1'b1) feSeen++;
    if (overrun === 1'b1) ovSeen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge sys_clk); #1;
      if (Baud16Tick) k++;
    end
  endtask

  // Drives one frame, changing the line in step with the ticks the DUT counts
  // (its START state begins three clocks after the falling edge is driven).
  // Optionally pops on exactly the stop-sample cycle; stopAt < 160 abandons early.
  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic popAtStop,
                           input int stopAt, output logic [7:0] popped);
    logic [9:0] frame;
    int cnt;
    frame  = {stopBit, d, 1'b0};
    cnt    = 0;
    popped = 8'h00;
    @(negedge sys_clk); #1;
    RxD_ser = 1'b0;
    repeat (3) @(posedge sys_clk);
    while (cnt < stopAt) begin
      @(negedge sys_clk); #1;
      TxD_pop = 1'b0;
      if ((cnt % 16) == 0 && cnt < 160) RxD_ser = frame[cnt / 16];
      if (Baud16Tick) begin
        cnt++;
        if (popAtStop && cnt == 152) begin
          popped  = TxD_par;
          TxD_pop = 1'b1;
        end
      end
    end
    @(negedge sys_clk); #1;
    TxD_pop = 1'b0;
    if (stopAt >= 160) begin
      RxD_ser = 1'b1;
      repeat (4) @(negedge sys_clk);
    end
  endtask

  task automatic popOne(output logic [7:0] got);
    @(negedge sys_clk); #1;
    got = TxD_par;
    TxD_pop = 1'b1;
    @(negedge sys_clk); #1;
    TxD_pop = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       popAfter;
    int         expLevel;
    logic [7:0] expHead;
    int         expFe;
    logic [7:0] expHeadAfterPop;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] got;
    int ovBase, feBase;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0, 8'h00};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1, 8'h00};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1, 8'h3C, 1, 8'h00};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 2, 8'h3C, 1, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 3, 8'h3C, 1, 8'h5A};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 3, 8'h5A, 1, 8'hFF};

    // Reset state, then CTS drops on the first edge after release.
    repeat (3) @(negedge sys_clk); #1;
    check("rst CTS", CTS, 1);
    check("rst valid", TxD_valid, 0);
    check("rst par", TxD_par, 8'h00);
    check("rst level", fifo_level, 0);
    check("rst frame_err", frame_err, 0);
    check("rst overrun", overrun, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk); #1;
    check("release CTS", CTS, 0);

    // Table of single frames.
    foreach (vecs[i]) begin
      sendFrame(vecs[i].data, vecs[i].stopBit, 1'b0, 160, got);
      check($sformatf("v%0d level", i), fifo_level, vecs[i].expLevel);
      check($sformatf("v%0d valid", i), TxD_valid, (vecs[i].expLevel != 0));
      if (vecs[i].expLevel != 0) check($sformatf("v%0d head", i), TxD_par, vecs[i].expHead);
      check($sformatf("v%0d frame_err count", i), feSeen, vecs[i].expFe);
      check($sformatf("v%0d overrun count", i), ovSeen, 0);
      if (vecs[i].popAfter) begin
        popOne(got);
        check($sformatf("v%0d popped", i), got, vecs[i].expHead);
        check($sformatf("v%0d level after pop", i), fifo_level, vecs[i].expLevel - 1);
        check($sformatf("v%0d valid after pop", i), TxD_valid, (vecs[i].expLevel > 1));
        if (vecs[i].expLevel > 1)
          check($sformatf("v%0d head after pop", i), TxD_par, vecs[i].expHeadAfterPop);
      end
    end
    popOne(got); check("drain FF", got, 8'hFF);
    popOne(got); check("drain 00", got, 8'h00);
    check("drained level", fifo_level, 0);
    check("drained valid", TxD_valid, 0);
    popOne(got);
    check("pop when empty level", fifo_level, 0);

    // Start-bit glitch: low for 5 ticks only.
    @(negedge sys_clk); #1;
    RxD_ser = 1'b0;
    waitTicks(5);
    RxD_ser = 1'b1;
    waitTicks(24);
    check("glitch level", fifo_level, 0);
    check("glitch frame_err count", feSeen, 1);
    sendFrame(8'h96, 1'b1, 1'b0, 160, got);
    check("after glitch level", fifo_level, 1);
    check("after glitch head", TxD_par, 8'h96);
    popOne(got);

    // CTS threshold at 12 entries.
    for (int i = 0; i < 12; i++) begin
      sendFrame(8'h10 + 8'(i), 1'b1, 1'b0, 160, got);
      if (i == 10) check("CTS at 11", CTS, 0);
    end
    check("CTS at 12", CTS, 1);
    check("level 12", fifo_level, 12);
    popOne(got);
    check("pop at 12", got, 8'h10);
    check("CTS at 11 after pop", CTS, 0);
    for (int j = 0; j < 11; j++) begin
      popOne(got);
      check($sformatf("cts drain %0d", j), got, 8'h11 + 8'(j));
    end
    check("cts drained level", fifo_level, 0);

    // 17 frames without pops: one overrun, first 16 kept.
    ovBase = ovSeen;
    for (int i = 0; i < 17; i++) begin
      sendFrame(8'h40 + 8'(i), 1'b1, 1'b0, 160, got);
      if (i == 15) begin
        check("full level", fifo_level, 16);
        check("full no overrun", ovSeen, ovBase);
      end
    end
    check("overrun once", ovSeen, ovBase + 1);
    check("overrun level", fifo_level, 16);
    check("overrun head", TxD_par, 8'h40);
    check("overrun CTS", CTS, 1);

    // Full FIFO: stop-bit push coinciding with a pop, 40 streamed bytes.
    ovBase = ovSeen;
    for (int k = 0; k < 40; k++) begin
      sendFrame(8'(k), 1'b1, 1'b1, 160, got);
      check($sformatf("stream pop %0d", k), got, (k < 16) ? 8'h40 + 8'(k) : 8'(k - 16));
      if (k == 0) begin
        check("push+pop full level", fifo_level, 16);
        check("push+pop full no overrun", ovSeen, ovBase);
      end
    end
    check("stream level", fifo_level, 16);
    check("stream no overrun", ovSeen, ovBase);
    for (int j = 0; j < 15; j++) begin
      popOne(got);
      check($sformatf("stream drain %0d", j), got, 8'h18 + 8'(j));
    end
    check("stream remaining level", fifo_level, 1);
    check("stream tail", TxD_par, 8'h27);

    // Reset during DATA bit 3 with the line low at release.
    ovBase = ovSeen;
    feBase = feSeen;
    sendFrame(8'h00, 1'b1, 1'b0, 64, got);
    sys_rst_n = 1'b0;
    #2;
    check("midrst level", fifo_level, 0);
    check("midrst valid", TxD_valid, 0);
    check("midrst par", TxD_par, 8'h00);
    check("midrst CTS", CTS, 1);
    check("midrst frame_err", frame_err, 0);
    check("midrst overrun", overrun, 0);
    repeat (3) @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
    waitTicks(40);
    check("post-rst low level", fifo_level, 0);
    check("post-rst low valid", TxD_valid, 0);
    check("post-rst frame_err", feSeen, feBase);
    RxD_ser = 1'b1;
    waitTicks(20);
    sendFrame(8'h81, 1'b1, 1'b0, 160, got);
    check("post-rst level", fifo_level, 1);
    check("post-rst head", TxD_par, 8'h81);
    check("post-rst no frame_err", feSeen, feBase);
    check("post-rst no overrun", ovSeen, ovBase);
    popOne(got);
    check("post-rst pop", got, 8'h81);
    check("post-rst CTS", CTS, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, number of received-byte entries; power of two, 4..64.
REQ-002 Parameter CTS_MARGIN, default 4, free entries at which CTS is deasserted; 1..FIFO_DEPTH-1.
REQ-003 sys_clk  in  1  system clock (27 MHz); every register is clocked on its rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to sys_clk.
REQ-005 Baud16Tick  in  1  one-sys_clk-wide strobe at 16x the baud rate (115200).
REQ-006 RxD_ser  in  1  serial line from the USB bridge; idle is high; 8N1, LSB first.
REQ-007 CTS  out  1  active-low "ready to receive" to the USB bridge.
REQ-008 TxD_par  out  8  byte at the FIFO head; valid only while TxD_valid=1.
REQ-009 TxD_valid  out  1  FIFO is not empty.
REQ-010 TxD_pop  in  1  FPGA consumes the head byte in this cycle.
REQ-011 frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun  out  1  one-cycle pulse: valid byte dropped because the FIFO was full.
REQ-013 fifo_level  out  clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.

Function
REQ-014 RxD_ser passes through a 2-FF synchronizer; both flops reset to 1; all line decisions use the synchronized value rx_s.
REQ-015 The receive FSM has exactly the states IDLE, START, DATA and STOP; a 4-bit tick counter and a 3-bit bit index advance only on Baud16Tick.
REQ-016 IDLE: a 1->0 transition of rx_s moves the FSM to START and clears the tick counter; a line held low does not retrigger.
REQ-017 START: on the 8th Baud16Tick (mid-bit), rx_s=0 moves the FSM to DATA with counter and bit index cleared; rx_s=1 is treated as a glitch and returns the FSM to IDLE.
REQ-018 DATA: on every 16th Baud16Tick, rx_s is shifted into the shift register LSB first; after bit index 7 the FSM moves to STOP.
REQ-019 STOP: on the 16th Baud16Tick, rx_s is sampled and the FSM returns to IDLE in the same cycle.
REQ-020 Stop sampled 1 with the FIFO not full: the byte is pushed and appears at the head no earlier than the next cycle.
REQ-021 Stop sampled 1 with the FIFO full: the byte is discarded and overrun pulses for one cycle, unless a pop occurs in the same cycle (REQ-024).
REQ-022 Stop sampled 0: the byte is discarded and frame_err pulses for one cycle.
REQ-023 The FIFO is first-word-fall-through: TxD_par is the oldest entry and TxD_valid=(fifo_level!=0).
REQ-024 A pop occurs when TxD_pop=1 and TxD_valid=1; TxD_pop while empty is ignored; a push and pop in the same cycle leave fifo_level unchanged and are both honoured, including when the FIFO is full.
REQ-025 Read and write pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH or goes below 0.
REQ-026 CTS is registered: it is driven 1 (stop) when fifo_level >= FIFO_DEPTH-CTS_MARGIN, and 0 (ready) otherwise.
REQ-027 A frame in progress completes regardless of CTS; flow control only affects subsequent frames, and the margin absorbs bytes still in flight.

Reset
REQ-028 While sys_rst_n=0: FSM=IDLE, counters=0, pointers=0, fifo_level=0, TxD_valid=0, TxD_par=0, frame_err=0, overrun=0, CTS=1, and synchronizer flops=1.
REQ-029 Reset asserted mid-frame abandons the frame with no push and no error pulse; after release, reception resumes only on a fresh 1->0 edge.
REQ-030 CTS goes to 0 on the first sys_clk edge after reset release.

Verification
REQ-031 Send 0xA5 with a valid stop bit -> the byte is received, then TxD_valid=1, TxD_par=0xA5, fifo_level=1; one TxD_pop -> TxD_valid=0.
REQ-032 Hold RxD_ser low for 5 Baud16Ticks, then high -> FSM returns to IDLE, no push, no frame_err.
REQ-033 Send 0x3C with the stop bit low -> frame_err pulses exactly once, fifo_level stays 0, and a following 0x3C with a valid stop bit is received correctly.
REQ-034 With depth 16 and margin 4, send 12 bytes with no pops -> CTS=1 after the 12th push; pop 1 -> CTS=0; send until 17 frames total without pops -> overrun pulses once and the FIFO holds the first 16 bytes in order.
REQ-035 FIFO full, with the stop-bit push coinciding with TxD_pop -> no overrun, fifo_level stays 16, the new byte is at the tail; pointers wrap correctly across 40 streamed bytes 0x00..0x27.
REQ-036 Assert sys_rst_n=0 during DATA bit 3 -> all outputs match REQ-028; the next full frame 0x81 is received correctly.
